// File: rtl/roce_stack_pkg.sv
// -----------------------------------------------------------------------------
// roce_stack_pkg
// Shared types for the RoCE stack.
//   dma_req_t     : {paddr[63:0], buflen[47:0], accesdesc[3:0]} returned to the
//                   request handlers as the result of an address lookup.
//   xlate_entry_t : one translation-table entry,
//                   {valid, base_vaddr[63:0], paddr[63:0], buflen[47:0],
//                    accesdesc[3:0]}.
//   xlate_state_e : lookup responder FSM states.
//   entry_hit()   : range match of a virtual address against one entry.
// -----------------------------------------------------------------------------
package roce_stack_pkg;

  typedef struct packed {
    logic [63:0] paddr;
    logic [47:0] buflen;
    logic [3:0]  accesdesc;
  } dma_req_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] base_vaddr;
    logic [63:0] paddr;
    logic [47:0] buflen;
    logic [3:0]  accesdesc;
  } xlate_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } xlate_state_e;

  localparam int unsigned STAT_W = 32;

  // An entry covers [base_vaddr, base_vaddr + buflen). A zero buflen covers
  // nothing, and the >= test keeps the wrapped subtraction from aliasing.
  function automatic logic entry_hit(input xlate_entry_t e,
                                     input logic [63:0] vaddr);
    logic [63:0] offset;
    offset = vaddr - e.base_vaddr;
    return e.valid && (vaddr >= e.base_vaddr) && (offset < {16'h0, e.buflen});
  endfunction

endpackage

// File: rtl/roce_stack_xlate_table.sv
// -----------------------------------------------------------------------------
// roce_stack_xlate_table
// NUM_ENTRIES-deep translation table: one write port, one combinational read.
//   clk_i, aresetn_i : clock, asynchronous active-low reset (clears valid bits)
//   wr_en_i          : write strobe (already qualified by the caller)
//   wr_idx_i         : entry to overwrite
//   wr_entry_i       : full entry contents, including valid
//   rd_idx_i         : entry to read
//   rd_entry_o       : contents of entry rd_idx_i
// -----------------------------------------------------------------------------
module roce_stack_xlate_table
  import roce_stack_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic               clk_i,
  input  logic               aresetn_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  xlate_entry_t       wr_entry_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output xlate_entry_t       rd_entry_o
);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [63:0]            base_q   [NUM_ENTRIES];
  logic [63:0]            paddr_q  [NUM_ENTRIES];
  logic [47:0]            buflen_q [NUM_ENTRIES];
  logic [3:0]             acc_q    [NUM_ENTRIES];

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_entry_i.valid;
    end
  end

  // NOTE: only the valid bits are reset; the payload is never observed while
  // its valid bit is low, so the storage array stays reset-free plain flops.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      base_q[wr_idx_i]   <= wr_entry_i.base_vaddr;
      paddr_q[wr_idx_i]  <= wr_entry_i.paddr;
      buflen_q[wr_idx_i] <= wr_entry_i.buflen;
      acc_q[wr_idx_i]    <= wr_entry_i.accesdesc;
    end
  end

  assign rd_entry_o = '{valid:      valid_q[rd_idx_i],
                        base_vaddr: base_q[rd_idx_i],
                        paddr:      paddr_q[rd_idx_i],
                        buflen:     buflen_q[rd_idx_i],
                        accesdesc:  acc_q[rd_idx_i]};

endmodule

// File: rtl/roce_stack_addr_xlate_responder.sv
// -----------------------------------------------------------------------------
// roce_stack_addr_xlate_responder
// Responder for the request-handler address lookup. A 64-bit virtual address
// accepted on req_addr is searched linearly through the translation table
// (lowest index wins) and a dma_req_t plus miss flag is returned on resp_addr.
//   clk_i, aresetn_i        : clock, asynchronous active-low reset
//   req_addr_*              : lookup request (valid/ready, vaddr)
//   resp_addr_*             : lookup response (valid/ready, data, miss)
//   cfg_wr_*                : table write port; stalled while a search runs
//   stat_hit_cnt_o / _miss_ : saturating counts of delivered responses
// Each table entry is fetched into a candidate register one cycle before it
// is compared, which keeps the read mux out of the 64-bit compare path. A hit
// on entry k is therefore presented k+2 cycles after accept, a miss
// NUM_ENTRIES+1 cycles after accept.
// -----------------------------------------------------------------------------
module roce_stack_addr_xlate_responder
  import roce_stack_pkg::*;
#(
  parameter  int unsigned NUM_ENTRIES = 16,
  localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk_i,
  input  logic                      aresetn_i,
  input  logic                      req_addr_valid_i,
  output logic                      req_addr_ready_o,
  input  logic [63:0]               req_addr_vaddr_i,
  output logic                      resp_addr_valid_o,
  input  logic                      resp_addr_ready_i,
  output logic [$bits(dma_req_t)-1:0] resp_addr_data_o,
  output logic                      resp_addr_miss_o,
  input  logic                      cfg_wr_valid_i,
  output logic                      cfg_wr_ready_o,
  input  logic [IDX_W-1:0]          cfg_wr_idx_i,
  input  logic [$bits(xlate_entry_t)-1:0] cfg_wr_entry_i,
  output logic [STAT_W-1:0]         stat_hit_cnt_o,
  output logic [STAT_W-1:0]         stat_miss_cnt_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  xlate_state_e      state_q;
  logic [63:0]       vaddr_q;
  logic [IDX_W-1:0]  rd_idx_q;     // entry being fetched
  logic [IDX_W-1:0]  cand_idx_q;   // index of the entry held in cand_q
  logic              cand_vld_q;   // cand_q holds a fetched entry
  xlate_entry_t      cand_q;
  dma_req_t          resp_q;
  logic              miss_q;
  logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic [STAT_W-1:0] hit_cnt_d, miss_cnt_d;

  xlate_entry_t      rd_entry;
  logic              cfg_wr_en;
  logic              cand_hit;
  logic [63:0]       cand_off;
  dma_req_t          hit_resp;

  // The table is written only outside SEARCH, so a search sees a frozen
  // table; a write in the accept cycle lands before entry 0 is fetched.
  assign cfg_wr_en = cfg_wr_valid_i && cfg_wr_ready_o;

  roce_stack_xlate_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk_i      (clk_i),
    .aresetn_i  (aresetn_i),
    .wr_en_i    (cfg_wr_en),
    .wr_idx_i   (cfg_wr_idx_i),
    .wr_entry_i (xlate_entry_t'(cfg_wr_entry_i)),
    .rd_idx_i   (rd_idx_q),
    .rd_entry_o (rd_entry)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit_resp           = '0;
    cand_off           = vaddr_q - cand_q.base_vaddr;
    cand_hit           = cand_vld_q && entry_hit(cand_q, vaddr_q);
    hit_resp.paddr     = cand_q.paddr + cand_off;
    hit_resp.buflen    = cand_q.buflen - cand_off[47:0];
    hit_resp.accesdesc = cand_q.accesdesc;
  end

  assign hit_cnt_d  = (hit_cnt_q  == '1) ? hit_cnt_q  : hit_cnt_q  + 1'b1;
  assign miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q    <= ST_IDLE;
      vaddr_q    <= '0;
      rd_idx_q   <= '0;
      cand_idx_q <= '0;
      cand_vld_q <= 1'b0;
      cand_q     <= '0;
      resp_q     <= '0;
      miss_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_addr_valid_i) begin
            vaddr_q    <= req_addr_vaddr_i;
            rd_idx_q   <= '0;
            cand_vld_q <= 1'b0;
            state_q    <= ST_SEARCH;
          end
        end

        ST_SEARCH: begin
          // Fetch stage: runs every SEARCH cycle; the wrap of rd_idx_q after
          // the last entry is harmless because the search ends first.
          cand_q     <= rd_entry;
          cand_idx_q <= rd_idx_q;
          cand_vld_q <= 1'b1;
          rd_idx_q   <= rd_idx_q + 1'b1;
          // Compare stage on the previously fetched entry.
          if (cand_hit) begin
            resp_q  <= hit_resp;
            miss_q  <= 1'b0;
            state_q <= ST_RESP;
          end else if (cand_vld_q && (cand_idx_q == LAST_IDX)) begin
            resp_q  <= '0;
            miss_q  <= 1'b1;
            state_q <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_addr_ready_i) begin
            if (miss_q) miss_cnt_q <= miss_cnt_d;
            else        hit_cnt_q  <= hit_cnt_d;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_addr_ready_o  = (state_q == ST_IDLE);
  assign resp_addr_valid_o = (state_q == ST_RESP);
  assign cfg_wr_ready_o    = (state_q != ST_SEARCH);
  assign resp_addr_data_o  = resp_q;
  assign resp_addr_miss_o  = miss_q;
  assign stat_hit_cnt_o    = hit_cnt_q;
  assign stat_miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_roce_stack_addr_xlate_responder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for roce_stack_addr_xlate_responder. Expected responses
// come from a table model searched with a plain loop; latency expectations
// come from the documented k+2 / NUM_ENTRIES+1 rule.
// -----------------------------------------------------------------------------
module tb_roce_stack_addr_xlate_responder;
  import roce_stack_pkg::*;

  localparam int N  = 16;
  localparam int IW = $clog2(N);

  logic                         clk_i = 1'b0;
  logic                         aresetn_i;
  logic                         req_addr_valid_i;
  logic                         req_addr_ready_o;
  logic [63:0]                  req_addr_vaddr_i;
  logic                         resp_addr_valid_o;
  logic                         resp_addr_ready_i;
  logic [$bits(dma_req_t)-1:0]  resp_addr_data_o;
  logic                         resp_addr_miss_o;
  logic                         cfg_wr_valid_i;
  logic                         cfg_wr_ready_o;
  logic [IW-1:0]                cfg_wr_idx_i;
  logic [$bits(xlate_entry_t)-1:0] cfg_wr_entry_i;
  logic [31:0]                  stat_hit_cnt_o;
  logic [31:0]                  stat_miss_cnt_o;

  roce_stack_addr_xlate_responder #(.NUM_ENTRIES(N)) dut (
    .clk_i             (clk_i),
    .aresetn_i         (aresetn_i),
    .req_addr_valid_i  (req_addr_valid_i),
    .req_addr_ready_o  (req_addr_ready_o),
    .req_addr_vaddr_i  (req_addr_vaddr_i),
    .resp_addr_valid_o (resp_addr_valid_o),
    .resp_addr_ready_i (resp_addr_ready_i),
    .resp_addr_data_o  (resp_addr_data_o),
    .resp_addr_miss_o  (resp_addr_miss_o),
    .cfg_wr_valid_i    (cfg_wr_valid_i),
    .cfg_wr_ready_o    (cfg_wr_ready_o),
    .cfg_wr_idx_i      (cfg_wr_idx_i),
    .cfg_wr_entry_i    (cfg_wr_entry_i),
    .stat_hit_cnt_o    (stat_hit_cnt_o),
    .stat_miss_cnt_o   (stat_miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference table and counters.
  logic        m_vld  [N];
  logic [63:0] m_base [N];
  logic [63:0] m_pa   [N];
  logic [47:0] m_len  [N];
  logic [3:0]  m_acc  [N];
  int unsigned m_hits, m_misses;

  // Last expected response, for stability checks under backpressure.
  dma_req_t    last_exp;
  logic        last_miss;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_write(input int idx, input logic v, input logic [63:0] base,
                             input logic [63:0] pa, input logic [47:0] len,
                             input logic [3:0] acc);
    m_vld[idx] = v; m_base[idx] = base; m_pa[idx] = pa;
    m_len[idx] = len; m_acc[idx] = acc;
  endtask

  // First entry, scanning upward, whose [base, base+len) holds va.
  task automatic model_lookup(input logic [63:0] va, output logic hit,
                              output int k, output dma_req_t exp);
    logic [63:0] off;
    hit = 1'b0; k = -1; exp = '0;
    for (int i = 0; i < N; i++) begin
      off = va - m_base[i];
      if (!hit && m_vld[i] && va >= m_base[i] && off < {16'h0, m_len[i]}) begin
        hit = 1'b1; k = i;
        exp.paddr     = m_pa[i] + off;
        exp.buflen    = m_len[i] - off[47:0];
        exp.accesdesc = m_acc[i];
      end
    end
  endtask

  task automatic drive_cfg(input int idx, input logic v, input logic [63:0] base,
                           input logic [63:0] pa, input logic [47:0] len,
                           input logic [3:0] acc);
    cfg_wr_valid_i = 1'b1;
    cfg_wr_idx_i   = IW'(idx);
    cfg_wr_entry_i = {v, base, pa, len, acc};
  endtask

  // Table write in IDLE or RESP; called #1 after a rising edge.
  task automatic cfg_write(input int idx, input logic v, input logic [63:0] base,
                           input logic [63:0] pa, input logic [47:0] len,
                           input logic [3:0] acc);
    drive_cfg(idx, v, base, pa, len, acc);
    check("cfg_wr_ready", cfg_wr_ready_o, 1'b1);
    @(posedge clk_i); #1;
    cfg_wr_valid_i = 1'b0;
    model_write(idx, v, base, pa, len, acc);
  endtask

  // Issue a lookup, wait for the response and check latency and contents.
  // Any table write already driven is applied in the accept cycle.
  task automatic lookup(input logic [63:0] va, input string tag);
    logic     hit;
    int       k, lat, exp_lat;
    dma_req_t exp;
    check({tag, "_req_ready"}, req_addr_ready_o, 1'b1);
    req_addr_valid_i = 1'b1;
    req_addr_vaddr_i = va;
    @(posedge clk_i); #1;
    req_addr_valid_i = 1'b0;
    cfg_wr_valid_i   = 1'b0;
    model_lookup(va, hit, k, exp);
    lat = 0;
    while (!resp_addr_valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    exp_lat = hit ? k + 2 : N + 1;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, resp_addr_data_o, exp);
    check({tag, "_miss"}, resp_addr_miss_o, !hit);
    check({tag, "_no_accept"}, req_addr_ready_o, 1'b0);
    last_exp  = exp;
    last_miss = !hit;
  endtask

  task automatic consume(input string tag);
    resp_addr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_addr_ready_i = 1'b0;
    if (last_miss) m_misses++; else m_hits++;
    check({tag, "_valid_drop"}, resp_addr_valid_o, 1'b0);
    check({tag, "_idle_ready"}, req_addr_ready_o, 1'b1);
    check({tag, "_hit_cnt"}, stat_hit_cnt_o, m_hits);
    check({tag, "_miss_cnt"}, stat_miss_cnt_o, m_misses);
  endtask

  initial begin
    aresetn_i         = 1'b0;
    req_addr_valid_i  = 1'b0;
    req_addr_vaddr_i  = '0;
    resp_addr_ready_i = 1'b0;
    cfg_wr_valid_i    = 1'b0;
    cfg_wr_idx_i      = '0;
    cfg_wr_entry_i    = '0;
    last_exp          = '0;
    last_miss         = 1'b0;
    model_clear();

    // Reset values.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req_ready", req_addr_ready_o, 1'b1);
    check("rst_resp_valid", resp_addr_valid_o, 1'b0);
    check("rst_resp_data", resp_addr_data_o, '0);
    check("rst_resp_miss", resp_addr_miss_o, 1'b0);
    check("rst_cfg_ready", cfg_wr_ready_o, 1'b1);
    check("rst_hit_cnt", stat_hit_cnt_o, 0);
    check("rst_miss_cnt", stat_miss_cnt_o, 0);
    aresetn_i = 1'b1;
    @(posedge clk_i); #1;

    // Empty table: full-length miss.
    lookup(64'h0, "empty");
    consume("empty");

    // Basic hit at entry 3 and its range boundaries.
    cfg_write(3, 1'b1, 64'h1000, 64'hA000_0000, 48'h2000, 4'h5);
    lookup(64'h1800, "e3_mid");
    consume("e3_mid");
    lookup(64'h2FFF, "e3_last_byte");
    consume("e3_last_byte");
    lookup(64'h3000, "e3_past_end");
    consume("e3_past_end");
    lookup(64'h0FFF, "e3_before_base");
    consume("e3_before_base");

    // Write in the accept cycle is visible to that search; then invalidate.
    drive_cfg(0, 1'b1, 64'h8000, 64'hB000, 48'h100, 4'h7);
    model_write(0, 1'b1, 64'h8000, 64'hB000, 48'h100, 4'h7);
    lookup(64'h8010, "same_cycle_wr");
    consume("same_cycle_wr");
    cfg_write(0, 1'b0, 64'h8000, 64'hB000, 48'h100, 4'h7);
    lookup(64'h8010, "invalidated");
    consume("invalidated");

    // Zero-length entry never hits.
    cfg_write(2, 1'b1, 64'h5000, 64'hE000, 48'h0, 4'h2);
    lookup(64'h5000, "zero_len");
    consume("zero_len");

    // Overlap: entries 1 and 5 (and 3) cover 0x1000; entry 1 wins.
    cfg_write(1, 1'b1, 64'h1000, 64'hC000_0000, 48'h10, 4'h1);
    cfg_write(5, 1'b1, 64'h0F00, 64'hD000_0000, 48'h200, 4'h9);
    lookup(64'h1000, "overlap");
    consume("overlap");

    // Backpressure with an invalidating write during RESP.
    lookup(64'h1800, "bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        drive_cfg(3, 1'b0, 64'h0, 64'h0, 48'h0, 4'h0);
        check("bp_cfg_ready", cfg_wr_ready_o, 1'b1);
      end
      @(posedge clk_i); #1;
      cfg_wr_valid_i = 1'b0;
      if (i == 4) model_write(3, 1'b0, 64'h0, 64'h0, 48'h0, 4'h0);
      check("bp_valid_held", resp_addr_valid_o, 1'b1);
      check("bp_data_held", resp_addr_data_o, last_exp);
      check("bp_miss_held", resp_addr_miss_o, last_miss);
      check("bp_req_blocked", req_addr_ready_o, 1'b0);
    end
    consume("bp");
    lookup(64'h1800, "after_inval");
    consume("after_inval");

    // Reset during SEARCH drops the response and clears the table.
    cfg_write(3, 1'b1, 64'h1000, 64'hA000_0000, 48'h2000, 4'h5);
    req_addr_valid_i = 1'b1;
    req_addr_vaddr_i = 64'h1800;
    @(posedge clk_i); #1;
    req_addr_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("mid_search_cfg_stall", cfg_wr_ready_o, 1'b0);
    aresetn_i = 1'b0;
    #2;
    check("rst_mid_valid", resp_addr_valid_o, 1'b0);
    check("rst_mid_req_ready", req_addr_ready_o, 1'b1);
    check("rst_mid_hit_cnt", stat_hit_cnt_o, 0);
    check("rst_mid_miss_cnt", stat_miss_cnt_o, 0);
    @(posedge clk_i); #1;
    aresetn_i = 1'b1;
    model_clear();
    repeat (6) begin
      @(posedge clk_i); #1;
      check("post_rst_no_resp", resp_addr_valid_o, 1'b0);
    end
    lookup(64'h1800, "post_rst");
    consume("post_rst");

    // Randomized table contents and lookups.
    for (int it = 0; it < 30; it++) begin
      int          idx;
      logic [63:0] base, pa, va;
      logic [47:0] len;
      idx  = int'($urandom_range(0, N - 1));
      base = 64'($urandom_range(0, 15)) << 12;
      pa   = {$urandom, $urandom};
      len  = ($urandom_range(0, 7) == 0) ? 48'h0 : 48'($urandom_range(1, 16'h3000));
      cfg_write(idx, ($urandom_range(0, 4) != 0), base, pa, len, 4'($urandom));
      va = 64'($urandom_range(0, 20'h13FFF));
      lookup(va, "rand");
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk_i); #1;
          check("rand_hold", resp_addr_data_o, last_exp);
        end
      end
      consume("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
